uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- Boot-time program loader that sits upstream of the pipelined core.
- Receives a program image over UART and writes it word-by-word into the shared IMEM/DMEM block RAM through a dedicated write port.
- Holds the core in reset until the image is complete, then releases it.
- The core starts fetching from word 0 with memory already populated.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4)
ADDR_W, 13, memory word-address width; DEPTH = 2**ADDR_W words

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous and active-high
uart_rx  in  1  serial input, idle high, 8N1, LSB first; asynchronous to clk
mem_we  out  4  byte write enables to the RAM write port; 4'hF on a word write, else 0
mem_addr  out  ADDR_W  word index of the current write
mem_din  out  32  write data (little-endian assembled word)
core_rst_n  out  1  active-low reset to the core; 0 until load completes
busy  out  1  high from first header byte until DONE or ERROR
done  out  1  high in DONE (sticky until rst)
err  out  1  high in ERROR (sticky until rst)

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_din=0, core_rst_n=0, busy=0, done=0, err=0, FSM=IDLE, RX FSM idle.
- Asserting rst at any point, including mid-byte or mid-image, returns to these values immediately. Partially written RAM is not cleared.
- uart_rx passes through a 2-flop synchronizer (2 cycles of latency) before any use.
- Byte receiver:
  - Falling edge of the synchronized line starts a byte; wait CLKS_PER_BIT/2 cycles, then resample.
  - If the line is high on the resample, treat it as a glitch and return to idle with no byte.
  - Otherwise sample 8 data bits, then the stop bit, each CLKS_PER_BIT cycles apart.
  - Stop bit = 1: pulse byte_valid for one cycle with the data.
  - Stop bit = 0: pulse frame_err for one cycle instead.
- Protocol: 4-byte little-endian word count N, then N words of 4 little-endian bytes each.
- Main FSM:
  - IDLE: on first byte_valid store byte0 of N, go to HDR, busy=1.
  - HDR: collect bytes 1..3 of N.
    - On byte 3: N==0 goes to DONE.
    - N>DEPTH goes to ERROR.
    - Otherwise go to DATA with word counter=0.
  - DATA: shift bytes into a 32-bit assembly register, LSB byte first.
    - On the 4th byte, in the next cycle: mem_din=word, mem_addr=counter, mem_we=4'hF for exactly one cycle; then counter+=1.
    - When counter reaches N after that write, go to DONE (or CSUM if enabled).
  - DONE: busy=0, done=1; core_rst_n goes 1 one cycle after entering DONE and stays 1 until rst. Further UART bytes are ignored.
  - ERROR: busy=0, err=1, core_rst_n stays 0, bytes ignored. Exit only via rst.
- frame_err in any state except DONE/ERROR goes to ERROR.
- The byte counter within a word is 2 bits and wraps 3->0. The word counter is ADDR_W+1 bits, so N==DEPTH is legal and the last write goes to address DEPTH-1.
- A byte_valid in the same cycle as a pending mem write is impossible, because bytes are at least 10*CLKS_PER_BIT cycles apart. No write buffering is needed.

Optional Feature:
- Macro UART_LOADER_CSUM_EN.
- Defined:
  - The loader keeps a running 32-bit sum (mod 2^32) of all data words.
  - After the last word it enters CSUM and receives 4 little-endian checksum bytes.
  - Match goes to DONE; mismatch goes to ERROR.
  - For N==0 the checksum is still received and must equal 0.
- Undefined: no CSUM state or accumulator; DATA goes directly to DONE.

Decomposition:
- Shared package/header holds:
  - FSM state encodings IDLE, HDR, DATA, CSUM, DONE, ERROR;
  - BYTES_PER_WORD=4;
  - the derived CLKS_PER_BIT expression.
- One natural sub-module, uart_rx_byte: synchronizer, bit timer, and 8N1 sampler, with outputs byte_valid, byte_data[7:0], frame_err. It is reused later by a UART MMIO peripheral.

Test Plan:
All tests use bench parameters CLK_HZ=1000000, BAUD=100000 (10 clks/bit) and ADDR_W=4.
- N=2, words 0x00000013, 0xDEADBEEF: exactly two writes, (addr0, 0x00000013) and (addr1, 0xDEADBEEF), each with mem_we=4'hF for one cycle; done=1; core_rst_n rises 1 cycle after done.
- N=0: no writes; done=1 after the 4th header byte. With CSUM_EN, done=1 only after 4 bytes of 0x00; a nonzero checksum gives err=1.
- N=17 (>DEPTH=16): err=1 after header byte 3, no writes, core_rst_n held 0. N=16: 16 writes, last to addr 15, done=1.
- Stop bit driven 0 on the 2nd data byte: err=1, only previously completed words written, later bytes ignored.
- 3-cycle low glitch on uart_rx while idle: no byte_valid, FSM stays IDLE. Then rst pulsed mid-word during DATA: all outputs return to reset values asynchronously; a full reload afterwards succeeds.
- CSUM_EN, N=1, word 0x00000005, checksum 0x00000005: done=1. Repeat with checksum 0x00000006: err=1, core_rst_n stays 0.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM encodings, word geometry,
// and the bit-period derivation used by the byte receiver.
package uart_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Integer division; callers must keep the result >= 4 so the half-bit wait is nonzero.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Word-wide RAM write port driven by the loader (master) into the shared IMEM/DMEM (slave).
interface uart_loader_if #(
    parameter int ADDR_W = 13
);
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;

    modport master (output mem_we, mem_addr, mem_din);
    modport slave  (input  mem_we, mem_addr, mem_din);
endinterface

// File: rtl/uart_loader_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampler, glitch reject on the
// start bit, one-cycle byte_valid or frame_err pulse per frame.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // [0],[1] synchronize; [2] is the previous synchronized value for edge detect
    logic [2:0]    sync_pipe;
    logic          rx_s;
    logic          rx_prev;
    rx_state_t     rx_state, rx_state_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          tick;

    assign rx_s    = sync_pipe[1];
    assign rx_prev = sync_pipe[2];
    assign tick    = (cnt == ((rx_state == RX_START) ? HALF : FULL));

    always_comb begin
        rx_state_d = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s)            rx_state_d = RX_START;
            RX_START: if (tick)                        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7)     rx_state_d = RX_STOP;
            RX_STOP:  if (tick)                        rx_state_d = RX_IDLE;
            default:                                   rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe  <= '1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync_pipe  <= {sync_pipe[1:0], rx};
            rx_state   <= rx_state_d;
            cnt        <= (rx_state == RX_IDLE || tick) ? '0 : cnt + CW'(1);
            byte_valid <= (rx_state == RX_STOP) && tick && rx_s;
            frame_err  <= (rx_state == RX_STOP) && tick && !rx_s;
            if (rx_state == RX_START)
                bit_idx <= '0;
            if (rx_state == RX_DATA && tick) begin
                byte_data <= {rx_s, byte_data[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: receives a word-count header plus little-endian words over UART, writes them
// to RAM and then releases the core. UART_LOADER_CSUM_EN adds a trailing 32-bit checksum check.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rx,
    uart_loader_if.master mem,
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int          CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [31:0] DEPTH_W      = 32'(2 ** ADDR_W);
`ifdef UART_LOADER_CSUM_EN
    localparam state_t      END_ST       = ST_CSUM;
`else
    localparam state_t      END_ST       = ST_DONE;
`endif

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          frame_err;

    state_t        state, state_d;
    logic [1:0]    byte_cnt;
    logic [31:0]   asm_q;
    logic [31:0]   asm_nxt;
    logic [ADDR_W:0] n_words;
    logic [ADDR_W:0] wcnt;
    logic [ADDR_W:0] wcnt_inc;
    logic          wr_q;
    logic          take;
    logic          word_rdy;
`ifdef UART_LOADER_CSUM_EN
    logic [31:0]   sum_q;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign asm_nxt  = {byte_data, asm_q[31:8]};
    assign take     = (state == ST_IDLE) || (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign word_rdy = byte_valid && (byte_cnt == 2'd3);
    assign wcnt_inc = wcnt + {{ADDR_W{1'b0}}, 1'b1};

    assign busy = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERROR);

    always_comb begin
        state_d = state;
        if (frame_err && state != ST_DONE && state != ST_ERROR) begin
            state_d = ST_ERROR;
        end else begin
            case (state)
                ST_IDLE: if (byte_valid) state_d = ST_HDR;
                ST_HDR: begin
                    if (word_rdy) begin
                        if (asm_nxt == 32'd0)        state_d = END_ST;
                        else if (asm_nxt > DEPTH_W)  state_d = ST_ERROR;
                        else                         state_d = ST_DATA;
                    end
                end
                // Decide completion in the cycle the write is presented, counting it.
                ST_DATA: if (wr_q && wcnt_inc == n_words) state_d = END_ST;
`ifdef UART_LOADER_CSUM_EN
                ST_CSUM: if (word_rdy) state_d = (asm_nxt == sum_q) ? ST_DONE : ST_ERROR;
`endif
                default: state_d = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            asm_q        <= '0;
            n_words      <= '0;
            wcnt         <= '0;
            wr_q         <= 1'b0;
            mem.mem_we   <= '0;
            mem.mem_addr <= '0;
            mem.mem_din  <= '0;
            core_rst_n   <= 1'b0;
        end else begin
            state      <= state_d;
            core_rst_n <= (state == ST_DONE);
            wr_q       <= 1'b0;
            mem.mem_we <= '0;
            if (byte_valid && take) begin
                asm_q    <= asm_nxt;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == ST_HDR && word_rdy) begin
                n_words <= asm_nxt[ADDR_W:0];
                wcnt    <= '0;
            end
            if (state == ST_DATA && word_rdy) begin
                wr_q         <= 1'b1;
                mem.mem_we   <= 4'hF;
                mem.mem_din  <= asm_nxt;
                mem.mem_addr <= wcnt[ADDR_W-1:0];
            end
            if (wr_q)
                wcnt <= wcnt_inc;
        end
    end

`ifdef UART_LOADER_CSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       sum_q <= '0;
        else if (wr_q) sum_q <= sum_q + asm_q;
    end
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: table of load images plus hand sequences for glitch
// rejection and asynchronous reset mid-load.
module tb_uart_loader;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;
    logic core_rst_n, busy, done, err;

    uart_loader_if #(.ADDR_W(ADDR_W)) ifc ();

    uart_loader #(.CLK_HZ(1000000), .BAUD(100000), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .mem        (ifc.master),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int bad_we = 0;
    int nbv = 0;
    int cyc = 0;
    int done_cyc = -1;
    int rn_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (ifc.mem_we != 4'h0) begin
            wa.push_back(32'(ifc.mem_addr));
            wd.push_back(ifc.mem_din);
            if (ifc.mem_we != 4'hF) bad_we++;
        end
        if (dut.u_rx.byte_valid) nbv++;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (core_rst_n && rn_cyc < 0) rn_cyc = cyc;
    end

    typedef struct {
        string       name;
        logic [31:0] n;
        int          nsend;
        int          bad;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] cs_delta;
        int          exp_wr;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(10);
        end
        uart_rx = stop;
        tick(10);
        uart_rx = 1'b1;
        tick(3);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        uart_rx = 1'b1;
        tick(3);
        wa.delete();
        wd.delete();
        bad_we = 0;
        nbv = 0;
        done_cyc = -1;
        rn_cyc = -1;
        rst = 1'b0;
        tick(2);
    endtask

    function automatic logic [31:0] wgen(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return 32'h01010101 * 32'(i) + 32'h0a000000;
    endfunction

    task automatic check_outputs_reset(input string tag);
        chk({tag, "_we"},    32'(ifc.mem_we),   32'h0);
        chk({tag, "_addr"},  32'(ifc.mem_addr), 32'h0);
        chk({tag, "_din"},   ifc.mem_din,       32'h0);
        chk({tag, "_crstn"}, 32'(core_rst_n),   32'h0);
        chk({tag, "_busy"},  32'(busy),         32'h0);
        chk({tag, "_done"},  32'(done),         32'h0);
        chk({tag, "_err"},   32'(err),          32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] w;
        logic [31:0] sum;
        int k;
        do_reset();
        send_word(v.n);
        sum = 32'h0;
        k = 0;
        for (int i = 0; i < v.nsend; i++) begin
            w = wgen(v, i);
            sum = sum + w;
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8], (k != v.bad));
                k++;
            end
        end
`ifdef UART_LOADER_CSUM_EN
        send_word(sum + v.cs_delta);
`endif
        tick(30);
        chk({v.name, "_nwr"}, 32'(wa.size()), 32'(v.exp_wr));
        chk({v.name, "_we_val"}, 32'(bad_we), 32'h0);
        for (int i = 0; i < v.exp_wr && i < wa.size(); i++) begin
            chk($sformatf("%s_addr%0d", v.name, i), wa[i], 32'(i));
            chk($sformatf("%s_data%0d", v.name, i), wd[i], wgen(v, i));
        end
        chk({v.name, "_done"},  32'(done),       32'(v.exp_done));
        chk({v.name, "_err"},   32'(err),        32'(v.exp_err));
        chk({v.name, "_busy"},  32'(busy),       32'h0);
        chk({v.name, "_crstn"}, 32'(core_rst_n), 32'(v.exp_done));
        if (v.exp_done) chk({v.name, "_crstn_lag"}, 32'(rn_cyc - done_cyc), 32'd1);
        else            chk({v.name, "_crstn_held"}, 32'(rn_cyc), 32'hFFFFFFFF);
    endtask

    initial begin
        vecs.push_back('{"n2",      32'd2,  2,  -1, 32'h00000013, 32'hDEADBEEF, 32'd0, 2,  1'b1, 1'b0});
        vecs.push_back('{"n0",      32'd0,  0,  -1, 32'h0,        32'h0,        32'd0, 0,  1'b1, 1'b0});
        vecs.push_back('{"n17",     32'd17, 1,  -1, 32'h55AA55AA, 32'h0,        32'd0, 0,  1'b0, 1'b1});
        vecs.push_back('{"n16",     32'd16, 16, -1, 32'hCAFEF00D, 32'h12345678, 32'd0, 16, 1'b1, 1'b0});
        vecs.push_back('{"ferr_b1", 32'd2,  2,  1,  32'h04030201, 32'h08070605, 32'd0, 0,  1'b0, 1'b1});
        vecs.push_back('{"ferr_b5", 32'd2,  2,  5,  32'h04030201, 32'h08070605, 32'd0, 1,  1'b0, 1'b1});
`ifdef UART_LOADER_CSUM_EN
        vecs.push_back('{"cs_ok",   32'd1,  1,  -1, 32'h00000005, 32'h0,        32'd0, 1,  1'b1, 1'b0});
        vecs.push_back('{"cs_bad",  32'd1,  1,  -1, 32'h00000005, 32'h0,        32'd1, 1,  1'b0, 1'b1});
        vecs.push_back('{"cs_n0",   32'd0,  0,  -1, 32'h0,        32'h0,        32'd7, 0,  1'b0, 1'b1});
`endif

        tick(3);
        check_outputs_reset("rst0");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Short low pulse while idle must not be taken as a start bit.
        do_reset();
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(40);
        chk("glitch_bv",   32'(nbv),       32'h0);
        chk("glitch_busy", 32'(busy),      32'h0);
        chk("glitch_nwr",  32'(wa.size()), 32'h0);

        // Abort mid-word with an asynchronous reset, then reload from scratch.
        send_word(32'd2);
        send_word(32'h11223344);
        send_byte(8'h55, 1'b1);
        uart_rx = 1'b0;
        tick(4);
        chk("abort_busy", 32'(busy), 32'h1);
        chk("abort_din",  ifc.mem_din, 32'h11223344);
        chk("abort_nwr",  32'(wa.size()), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_outputs_reset("async");
        uart_rx = 1'b1;
        do_reset();
        send_word(32'd2);
        send_word(32'hAAAA0001);
        send_word(32'hBBBB0002);
`ifdef UART_LOADER_CSUM_EN
        send_word(32'hAAAA0001 + 32'hBBBB0002);
`endif
        tick(30);
        chk("reload_nwr", 32'(wa.size()), 32'h2);
        if (wa.size() == 2) begin
            chk("reload_a1", wa[1], 32'h1);
            chk("reload_d0", wd[0], 32'hAAAA0001);
            chk("reload_d1", wd[1], 32'hBBBB0002);
        end
        chk("reload_done",  32'(done),       32'h1);
        chk("reload_crstn", 32'(core_rst_n), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
